// File: rtl/pipeline_fetch_unit_if.sv
// pipeline_fetch_unit_if: request/response bus to instruction memory, redirect
// input and the decode-side valid/ready handshake of the fetch front end.
interface pipeline_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_ready;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/pipeline_fetch_unit.sv
// pipeline_fetch_unit: in-order instruction fetch front end. Issues word
// fetches under a credit limit, buffers returned words with their PCs in a
// shift-register prefetch FIFO whose entry 0 drives decode directly, and drops
// responses that belong to fetches made before a branch redirect.
// Optional feature macro: FETCH_STALL_CNT_EN adds the stall_cnt starvation counter.
module pipeline_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_fetch_unit_if.master bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]       DEPTH_C   = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP_C = {{(ADDR_W-3){1'b0}}, 3'b100};
    localparam logic [CW-1:0]     CNT_ZERO  = {CW{1'b0}};

    typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t                state_r;
    logic [ADDR_W-1:0]     fetch_pc_r;
    logic [ADDR_W-1:0]     rsp_pc_r;
    logic [CW-1:0]         outstanding_r;
    logic [CW-1:0]         stale_r;
    logic [CW-1:0]         count_r;
    logic [FIFO_DEPTH-1:0] ent_vld_r;
    logic [ADDR_W-1:0]     ent_pc_r    [FIFO_DEPTH];
    logic [DATA_W-1:0]     ent_instr_r [FIFO_DEPTH];

    logic                  credit_ok_s;
    logic                  req_valid_s;
    logic                  accept_s;
    logic                  pop_s;
    logic                  rsp_live_s;
    logic                  rsp_drop_s;
    logic [CW-1:0]         push_idx_s;
    logic [CW-1:0]         outstanding_nxt_s;
    logic [CW-1:0]         stale_nxt_s;
    logic [CW-1:0]         count_nxt_s;

    function automatic logic [CW-1:0] to_cnt(input logic b);
        to_cnt = {{(CW-1){1'b0}}, b};
    endfunction

    // Buffered plus in-flight words never exceed the FIFO, so a push always has room.
    assign credit_ok_s = ({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_C;
    assign req_valid_s = reset && credit_ok_s && !bus.redirect_valid;
    assign accept_s    = req_valid_s && bus.imem_req_ready;
    assign pop_s       = ent_vld_r[0] && bus.if_ready;
    assign rsp_live_s  = bus.imem_rsp_valid && (state_r == RUN) && !bus.redirect_valid;
    assign rsp_drop_s  = bus.imem_rsp_valid && (state_r == DRAIN) && !bus.redirect_valid;
    assign push_idx_s  = count_r - to_cnt(pop_s);

    // Next values of the in-flight counters and FIFO occupancy; redirect dominates.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        stale_nxt_s       = stale_r;
        count_nxt_s       = count_r;
        if (bus.redirect_valid) begin
            outstanding_nxt_s = CNT_ZERO;
            stale_nxt_s       = stale_r + outstanding_r - to_cnt(bus.imem_rsp_valid);
            count_nxt_s       = CNT_ZERO;
        end else begin
            outstanding_nxt_s = outstanding_r + to_cnt(accept_s) - to_cnt(rsp_live_s);
            count_nxt_s       = count_r + to_cnt(rsp_live_s) - to_cnt(pop_s);
            if (rsp_drop_s) begin
                stale_nxt_s = stale_r - to_cnt(1'b1);
            end else begin
                stale_nxt_s = stale_r;
            end
        end
    end

    // Fetch control FSM: RUN accepts responses, DRAIN discards pre-redirect ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= RUN;
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            stale_r       <= CNT_ZERO;
            count_r       <= CNT_ZERO;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            stale_r       <= stale_nxt_s;
            count_r       <= count_nxt_s;
            case (state_r)
                RUN:     state_r <= (stale_nxt_s != CNT_ZERO) ? DRAIN : RUN;
                DRAIN:   state_r <= (stale_nxt_s == CNT_ZERO) ? RUN : DRAIN;
                default: state_r <= RUN;
            endcase
            if (bus.redirect_valid) begin
                fetch_pc_r <= bus.redirect_pc;
                rsp_pc_r   <= bus.redirect_pc;
            end else begin
                if (accept_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP_C;
                end
                if (rsp_live_s) begin
                    rsp_pc_r <= rsp_pc_r + PC_STEP_C;
                end
            end
        end
    end

    // Prefetch FIFO as a shift register: pops shift toward entry 0, pushes land behind the last valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_vld_r <= {FIFO_DEPTH{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_pc_r[i]    <= {ADDR_W{1'b0}};
                ent_instr_r[i] <= {DATA_W{1'b0}};
            end
        end else if (bus.redirect_valid) begin
            ent_vld_r <= {FIFO_DEPTH{1'b0}};
        end else begin
            if (pop_s) begin
                for (int i = 0; i < FIFO_DEPTH-1; i++) begin
                    ent_vld_r[i]   <= ent_vld_r[i+1];
                    ent_pc_r[i]    <= ent_pc_r[i+1];
                    ent_instr_r[i] <= ent_instr_r[i+1];
                end
                ent_vld_r[FIFO_DEPTH-1]   <= 1'b0;
                ent_pc_r[FIFO_DEPTH-1]    <= {ADDR_W{1'b0}};
                ent_instr_r[FIFO_DEPTH-1] <= {DATA_W{1'b0}};
            end
            if (rsp_live_s) begin
                ent_vld_r[push_idx_s[IW-1:0]]   <= 1'b1;
                ent_pc_r[push_idx_s[IW-1:0]]    <= rsp_pc_r;
                ent_instr_r[push_idx_s[IW-1:0]] <= bus.imem_rsp_data;
            end
        end
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.if_valid       = ent_vld_r[0];
    assign bus.if_pc          = ent_pc_r[0];
    assign bus.if_instr       = ent_instr_r[0];

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Count cycles where decode is ready but nothing is buffered, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (bus.if_ready && !ent_vld_r[0] && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif
endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// tb_pipeline_fetch_unit: drives the fetch unit with an in-order memory model
// and checks it cycle by cycle against a transaction-level model built from
// queues: every accepted fetch is a record carrying its address, data and a
// "live" flag cleared by redirects; live responses enter an expected FIFO.
module tb_pipeline_fetch_unit;
    localparam int DEPTH = 4;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
        logic [31:0] data;
        bit          live;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    pipeline_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    pipeline_fetch_unit #(
        .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int          lat = 1;
    bit          drv_req_ready = 1'b0;
    bit          drv_if_ready = 1'b0;
    bit          drv_redirect = 1'b0;
    logic [31:0] drv_redirect_pc = 32'h0;
    logic [31:0] model_pc = 32'h0;
    logic [31:0] exp_stall = 32'h0;
    req_t        mem_q[$];
    ent_t        exp_q[$];

    bit          obs_req_valid, obs_acc, obs_if_valid, obs_pop;
    logic [31:0] obs_addr, obs_if_pc, obs_stall;

    // One clock cycle: apply inputs, check outputs against the model, advance the model.
    task automatic step();
        bit   rsp;
        bit   exp_rv;
        int   live;
        req_t r;
        int unsigned due;
        bus.imem_req_ready = drv_req_ready;
        bus.if_ready       = drv_if_ready;
        bus.redirect_valid = drv_redirect;
        bus.redirect_pc    = drv_redirect_pc;
        rsp = (mem_q.size() > 0) && (mem_q[0].due == cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_q[0].data : 32'h0;
        @(negedge clk);
        live = 0;
        foreach (mem_q[i]) if (mem_q[i].live) live++;
        exp_rv = ((exp_q.size() + live) < DEPTH) && !drv_redirect;
        total++;
        if (bus.imem_req_valid !== exp_rv) begin
            bad++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.imem_req_valid, exp_rv);
        end
        total++;
        if (bus.imem_req_addr !== model_pc) begin
            bad++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_req_addr, model_pc);
        end
        total++;
        if (bus.if_valid !== (exp_q.size() > 0)) begin
            bad++;
            $display("FAIL if_valid cyc=%0d got=%b exp=%b", cyc, bus.if_valid, exp_q.size() > 0);
        end
        if (exp_q.size() > 0) begin
            total++;
            if (bus.if_pc !== exp_q[0].pc || bus.if_instr !== exp_q[0].instr) begin
                bad++;
                $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                         cyc, bus.if_pc, bus.if_instr, exp_q[0].pc, exp_q[0].instr);
            end
        end
`ifdef FETCH_STALL_CNT_EN
        total++;
        if (stall_cnt !== exp_stall) begin
            bad++;
            $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, exp_stall);
        end
        obs_stall = stall_cnt;
`else
        obs_stall = 32'h0;
`endif
        obs_req_valid = bus.imem_req_valid;
        obs_acc       = bus.imem_req_valid && drv_req_ready;
        obs_addr      = bus.imem_req_addr;
        obs_if_valid  = bus.if_valid;
        obs_if_pc     = bus.if_pc;
        obs_pop       = bus.if_valid && drv_if_ready;
        if (drv_if_ready && exp_q.size() == 0 && exp_stall != 32'hFFFF_FFFF) exp_stall++;
        if (obs_pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (rsp) begin
            r = mem_q.pop_front();
            if (r.live && !drv_redirect) exp_q.push_back('{pc: r.addr, instr: r.data});
        end
        if (drv_redirect) begin
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            exp_q.delete();
            model_pc = drv_redirect_pc;
        end
        if (obs_acc) begin
            due = cyc + lat;
            if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
            mem_q.push_back('{due: due, addr: model_pc, data: $urandom(), live: 1'b1});
            model_pc = model_pc + 32'd4;
        end
        drv_redirect = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset values, optionally asserting reset in the middle of traffic.
    task automatic test_reset(input bit mid);
        reset = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b1;
        if (mid) begin
            #2;
            total++;
            if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL async_reset got if_valid=%b req_valid=%b exp 0 0",
                         bus.if_valid, bus.imem_req_valid);
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_req_valid got=%b exp=0", bus.imem_req_valid);
        end
        total++;
        if (bus.imem_req_addr !== 32'h0) begin
            bad++;
            $display("FAIL rst_req_addr got=%h exp=0", bus.imem_req_addr);
        end
        total++;
        if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin
            bad++;
            $display("FAIL rst_head got v=%b pc=%h instr=%h exp 0 0 0", bus.if_valid, bus.if_pc, bus.if_instr);
        end
`ifdef FETCH_STALL_CNT_EN
        total++;
        if (stall_cnt !== 32'h0) begin
            bad++;
            $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt);
        end
`endif
        mem_q.delete();
        exp_q.delete();
        model_pc = 32'h0;
        exp_stall = 32'h0;
        drv_redirect = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Latency 1 streaming: back-to-back requests and one instruction per cycle.
    task automatic test_basic_stream();
        int first_v = -1;
        int pops = 0;
        logic [31:0] first_pc = 32'hx;
        test_reset(1'b0);
        lat = 1; drv_req_ready = 1'b1; drv_if_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i < 3) begin
                total++;
                if (obs_acc !== 1'b1 || obs_addr !== 32'(4 * i)) begin
                    bad++;
                    $display("FAIL stream_req%0d got acc=%b addr=%h exp acc=1 addr=%h", i, obs_acc, obs_addr, 32'(4 * i));
                end
            end
            if (first_v < 0 && obs_if_valid) begin
                first_v = i;
                first_pc = obs_if_pc;
            end
            if (obs_pop) pops++;
        end
        total++;
        if (first_v != 2 || first_pc !== 32'h0) begin
            bad++;
            $display("FAIL first_valid got cycle=%0d pc=%h exp cycle=2 pc=0", first_v, first_pc);
        end
        total++;
        if (pops != 10) begin
            bad++;
            $display("FAIL throughput got pops=%0d exp=10", pops);
        end
    endtask

    // Decode stalled: credits cap fetches at the FIFO depth, pop re-opens one next cycle.
    task automatic test_full();
        int accs = 0;
        int p = -1;
        int q = -1;
        logic [31:0] qa = 32'hx;
        test_reset(1'b0);
        lat = 1; drv_req_ready = 1'b1; drv_if_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_acc) accs++;
        end
        total++;
        if (accs != 4) begin
            bad++;
            $display("FAIL full_reqs got=%0d exp=4", accs);
        end
        total++;
        if (obs_if_valid !== 1'b1 || obs_if_pc !== 32'h0) begin
            bad++;
            $display("FAIL full_head got v=%b pc=%h exp v=1 pc=0", obs_if_valid, obs_if_pc);
        end
        drv_if_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (p < 0 && obs_pop) p = i;
            if (q < 0 && obs_acc) begin
                q = i;
                qa = obs_addr;
            end
        end
        total++;
        if (p < 0 || q != p + 1 || qa !== 32'h10) begin
            bad++;
            $display("FAIL refill got pop=%0d req=%0d addr=%h exp req=pop+1 addr=10", p, q, qa);
        end
    endtask

    // Redirect with two fetches outstanding at latency 3.
    task automatic test_redirect();
        int found = 0;
        test_reset(1'b0);
        lat = 3; drv_req_ready = 1'b1; drv_if_ready = 1'b1;
        step();
        step();
        drv_redirect = 1'b1; drv_redirect_pc = 32'h40;
        step();
        total++;
        if (obs_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_withdraw got=%b exp=0", obs_req_valid);
        end
        step();
        total++;
        if (obs_acc !== 1'b1 || obs_addr !== 32'h40) begin
            bad++;
            $display("FAIL redir_addr got acc=%b addr=%h exp acc=1 addr=40", obs_acc, obs_addr);
        end
        for (int i = 0; i < 15 && found == 0; i++) begin
            step();
            if (obs_if_valid) begin
                found = 1;
                total++;
                if (obs_if_pc !== 32'h40) begin
                    bad++;
                    $display("FAIL redir_first got pc=%h exp=40", obs_if_pc);
                end
            end
        end
        if (found == 0) begin
            total++; bad++;
            $display("FAIL redir_timeout got no if_valid exp pc=40");
        end
    endtask

    // Redirect in the same cycle as a response with one more fetch in flight.
    task automatic test_redirect_rsp();
        int found = 0;
        test_reset(1'b0);
        lat = 2; drv_req_ready = 1'b1; drv_if_ready = 1'b1;
        step();
        step();
        drv_redirect = 1'b1; drv_redirect_pc = 32'h80;
        step();
        for (int i = 0; i < 15 && found == 0; i++) begin
            step();
            if (obs_if_valid) begin
                found = 1;
                total++;
                if (obs_if_pc !== 32'h80) begin
                    bad++;
                    $display("FAIL redir_rsp_first got pc=%h exp=80", obs_if_pc);
                end
            end
        end
        if (found == 0) begin
            total++; bad++;
            $display("FAIL redir_rsp_timeout got no if_valid exp pc=80");
        end
    endtask

    // Memory back-pressure: held address, no skipped or repeated PCs afterwards.
    task automatic test_backpressure();
        logic [31:0] nxt = 32'h0;
        test_reset(1'b0);
        lat = 1; drv_req_ready = 1'b1; drv_if_ready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            drv_req_ready = !(i >= 3 && i < 8);
            step();
            if (i >= 3 && i < 8) begin
                total++;
                if (obs_req_valid !== 1'b1 || obs_addr !== 32'hC) begin
                    bad++;
                    $display("FAIL bp_hold%0d got v=%b addr=%h exp v=1 addr=c", i, obs_req_valid, obs_addr);
                end
            end
            if (obs_pop) begin
                total++;
                if (obs_if_pc !== nxt) begin
                    bad++;
                    $display("FAIL bp_seq got pc=%h exp=%h", obs_if_pc, nxt);
                end
                nxt = nxt + 32'd4;
            end
        end
        total++;
        if (nxt < 32'h30) begin
            bad++;
            $display("FAIL bp_progress got next_pc=%h exp>=30", nxt);
        end
    endtask

    // Random traffic: variable latency, back-pressure on both sides, redirects incl. PC wrap.
    task automatic test_random();
        int dead;
        test_reset(1'b0);
        lat = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 5);
            drv_req_ready = ($urandom_range(0, 3) != 0);
            drv_if_ready  = ($urandom_range(0, 9) < 7);
            dead = 0;
            foreach (mem_q[k]) if (!mem_q[k].live) dead++;
            if (dead <= 3 && $urandom_range(0, 19) == 0) begin
                drv_redirect = 1'b1;
                drv_redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
            end
            step();
        end
    endtask

`ifdef FETCH_STALL_CNT_EN
    // Starvation count from reset until the first instruction at latency 4.
    task automatic test_stall();
        int found = 0;
        test_reset(1'b0);
        lat = 4; drv_req_ready = 1'b1; drv_if_ready = 1'b1;
        for (int i = 0; i < 12 && found == 0; i++) begin
            step();
            if (obs_if_valid) begin
                found = 1;
                total++;
                if (obs_stall !== 32'd5) begin
                    bad++;
                    $display("FAIL stall_first got=%0d exp=5", obs_stall);
                end
            end
        end
        if (found == 0) begin
            total++; bad++;
            $display("FAIL stall_timeout got no if_valid exp stall=5");
        end
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        test_reset(1'b0);
        test_basic_stream();
        test_full();
        test_redirect();
        test_redirect_rsp();
        test_backpressure();
        test_random();
        test_reset(1'b1);
`ifdef FETCH_STALL_CNT_EN
        test_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_fetch_unit.md
# pipeline_fetch_unit

Instruction fetch front end feeding the decode stage of the 4-stage pipeline. Issues in-order word fetches to instruction memory, buffers returned words with their PCs in a small prefetch FIFO, and presents them to decode over a valid/ready handshake. Also handles branch redirects by flushing the buffered words and discarding the responses still in flight.

## Interface
- `ADDR_W`, default 32: PC and memory address width.
- `DATA_W`, default 32: instruction width.
- `FIFO_DEPTH`, default 4: prefetch entries; power of two, ≥2.
- `RESET_PC`, default 0: fetch address after reset; word-aligned.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  ADDR_W  byte address of the requested word.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response word valid; responses return in order, latency ≥1 cycle.
- `imem_rsp_data`  in  DATA_W  instruction word.
- `redirect_valid`  in  1  branch/jump redirect, one-cycle pulse.
- `redirect_pc`  in  ADDR_W  new fetch PC; word-aligned.
- `if_valid`  out  1  head entry valid toward decode.
- `if_instr`  out  DATA_W  head instruction.
- `if_pc`  out  ADDR_W  PC of head instruction.
- `if_ready`  in  1  decode accepts head.
- `stall_cnt`  out  32  starvation counter; present only with `FETCH_STALL_CNT_EN`.

## Operation
- Registers: `fetch_pc` (next request address), `rsp_pc` (PC tagged on the next accepted response), `outstanding` (requests accepted but not yet answered), `stale` (responses to drop), and a FIFO of {pc, instr}.
- FSM:
  - RUN: `stale==0`.
  - DRAIN: `stale>0`. Responses are dropped and decrement `stale`; entering `stale==0` returns to RUN.
  - Requests may issue in both states.
- Credit rule: `imem_req_valid = (occupancy + outstanding < FIFO_DEPTH) && !redirect_valid`. The FIFO therefore never overflows.
- On `imem_req_valid && imem_req_ready`: `fetch_pc += 4`, `outstanding += 1`.
- On a non-stale response: push {`rsp_pc`, `imem_rsp_data`}, `rsp_pc += 4`, `outstanding -= 1`.
- Pop on `if_valid && if_ready`. `if_instr` and `if_pc` come from a registered FIFO head. There is no response-to-output bypass.
- Redirect (highest priority):
  - `fetch_pc` and `rsp_pc` are set to `redirect_pc`, and the FIFO is cleared.
  - `stale` is set to `outstanding` plus the current `stale`, minus 1 if `imem_rsp_valid` is high this cycle.
  - Any response arriving in the redirect cycle is dropped.
  - A decode handshake in the redirect cycle completes normally; squashing it is decode's job.
- Arithmetic: PC increments wrap modulo 2^ADDR_W. Counters are sized `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- Reset values:
  - `imem_req_valid=0` while reset is asserted; it goes high on the first cycle after release.
  - `imem_req_addr=RESET_PC`.
  - `if_valid=0`, `if_instr=0`, `if_pc=0`, `stall_cnt=0`.
  - FSM in RUN, all counters 0.
- Latency:
  - Request accepted in cycle N, response in cycle N+L: the entry is visible on `if_valid` in cycle N+L+1.
  - Minimum fetch-to-decode latency is 2 cycles.
- Throughput: one instruction per cycle sustained when L < FIFO_DEPTH.
- Empty FIFO with push and pop in the same cycle: pop is impossible (`if_valid=0`); the entry appears next cycle.
- Full FIFO: requests stall. A pop in cycle N frees a credit, so a request can issue in cycle N+1.
- Redirect while in DRAIN: stale counts accumulate.
- Reset asserted mid-operation: all state clears immediately. Responses from memory after reset are not tracked; the memory model is reset together with this block.
- `imem_req_addr` is held stable while `imem_req_valid && !imem_req_ready`, unless a redirect occurs, which withdraws the request.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stall_cnt` port and register exist.
  - The counter increments on every cycle with `if_ready && !if_valid`, saturates at 0xFFFF_FFFF, and clears on reset.
- Not defined: the port and logic are absent and all other behaviour is identical.

## Test plan
- Reset release, `RESET_PC=0`, memory latency 1, `if_ready=1`: requests at 0x0, 0x4, 0x8 in consecutive cycles; first `if_valid` 2 cycles after the first request with `if_pc=0x0`, then one instruction per cycle in PC order.
- `if_ready=0` for 10 cycles: exactly 4 requests are issued; `if_valid` stays high with `if_pc=0x0`; `if_ready=1` drains 0x0..0xC, and refill starts at 0x10.
- Latency 3 and `redirect_pc=0x40` while 2 requests are outstanding: next request address 0x40; the 2 late responses are dropped; the next `if_pc` is 0x40.
- Redirect in the same cycle as a response, with 1 other request outstanding: the current response is dropped, `stale=1`, and the first delivered entry has `if_pc=redirect_pc`.
- `imem_req_ready` low for 5 cycles: `imem_req_addr` holds its value, with no skipped or duplicated PCs afterwards.
- With `FETCH_STALL_CNT_EN`, latency 4 and `if_ready=1` from reset: `stall_cnt=5` at the first `if_valid`. Without the macro, the bench compiles without the port.
